// File: rtl/sampler_mixer_pkg.sv
// Shared types and helpers for the sampler voice mixer: FSM states, widths
// and the shift-and-saturate step applied to each channel sum.
package sampler_mixer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUTPUT} mixer_state_t;

  // Upper bounds for the width-generic saturation helper.
  localparam int unsigned MAX_ACC_WIDTH    = 128;
  localparam int unsigned MAX_SAMPLE_WIDTH = 64;

  localparam int unsigned DEF_GAIN_WIDTH = 16;
  localparam logic [DEF_GAIN_WIDTH-1:0] GAIN_UNITY =
    DEF_GAIN_WIDTH'(1) << (DEF_GAIN_WIDTH - 1);

  typedef logic signed [MAX_ACC_WIDTH-1:0] wide_acc_t;

  typedef struct packed {
    logic                                clip;
    logic signed [MAX_SAMPLE_WIDTH-1:0]  value;
  } sat_result_t;

  function automatic int unsigned acc_width(input int unsigned num_voices,
                                            input int unsigned sample_width,
                                            input int unsigned gain_width);
    return sample_width + gain_width + 32'd1 + 32'($clog2(num_voices));
  endfunction

  // Floor-shift the sum down to sample scale, then clamp to sample_w signed bits.
  function automatic sat_result_t sat_shift(input wide_acc_t   acc,
                                            input int unsigned shift,
                                            input int unsigned sample_w);
    wide_acc_t   shifted;
    wide_acc_t   hi;
    wide_acc_t   lo;
    sat_result_t r;
    shifted = acc >>> shift;
    hi      = $signed((MAX_ACC_WIDTH'(1) << (sample_w - 32'd1)) - MAX_ACC_WIDTH'(1));
    lo      = $signed(-hi - $signed(MAX_ACC_WIDTH'(1)));
    r.clip  = 1'b0;
    r.value = MAX_SAMPLE_WIDTH'(shifted);
    if (shifted > hi) begin
      r.clip  = 1'b1;
      r.value = MAX_SAMPLE_WIDTH'(hi);
    end else if (shifted < lo) begin
      r.clip  = 1'b1;
      r.value = MAX_SAMPLE_WIDTH'(lo);
    end
    return r;
  endfunction

endpackage

// File: rtl/sampler_voice_mixer_if.sv
// Voice-side and codec-side signals of the mixer; the mixer sits on the slave modport.
interface sampler_voice_mixer_if #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned GAIN_WIDTH   = 16,
  parameter int unsigned STAT_WIDTH   = 16
);

  logic [NUM_VOICES-1:0]              voice_en;
  logic [NUM_VOICES*GAIN_WIDTH-1:0]   voice_gain;
  logic [NUM_VOICES-1:0]              voice_valid;
  logic [NUM_VOICES-1:0]              voice_ready;
  logic [NUM_VOICES*2*SAMPLE_WIDTH-1:0] voice_data;
  logic                               frame_req;
  logic                               fifo_full;
  logic [2*SAMPLE_WIDTH-1:0]          data_out;
  logic                               data_wr;
  logic                               busy;
  logic                               clear_stats;
  logic [STAT_WIDTH-1:0]              clip_count;
  logic [STAT_WIDTH-1:0]              underrun_count;
  logic                               frame_overrun;

  modport master (
    output voice_en, voice_gain, voice_valid, voice_data, frame_req,
           fifo_full, clear_stats,
    input  voice_ready, data_out, data_wr, busy, clip_count,
           underrun_count, frame_overrun
  );

  modport slave (
    input  voice_en, voice_gain, voice_valid, voice_data, frame_req,
           fifo_full, clear_stats,
    output voice_ready, data_out, data_wr, busy, clip_count,
           underrun_count, frame_overrun
  );

endinterface

// File: rtl/sampler_mix_mac.sv
// One channel of the mixer: signed sample x unsigned gain accumulation, then
// shift/saturate into a registered result when finish is asserted.
module sampler_mix_mac
  import sampler_mixer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned GAIN_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH    = 43
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           en,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic        [GAIN_WIDTH-1:0]   gain,
  input  logic                           finish,
  output logic signed [SAMPLE_WIDTH-1:0] result,
  output logic                           clipped
);

  localparam int unsigned PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  acc;
  sat_result_t                  sat;

  // Gain is zero-extended so the full unsigned range multiplies as positive.
  assign product = PROD_WIDTH'(sample) * $signed(PROD_WIDTH'({1'b0, gain}));

  assign sat     = sat_shift(MAX_ACC_WIDTH'(acc), GAIN_WIDTH - 32'd1, SAMPLE_WIDTH);
  assign clipped = sat.clip;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + ACC_WIDTH'(product);
      end
      if (finish) begin
        result <= SAMPLE_WIDTH'(sat.value);
      end
    end
  end

endmodule

// File: rtl/sampler_voice_mixer.sv
// N-voice stereo mixer: walks one voice per cycle through a shared L/R MAC pair,
// saturates, and writes one {L,R} frame to the codec FIFO per frame_req.
module sampler_voice_mixer
  import sampler_mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned GAIN_WIDTH   = 16,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                  axi_clk,
  input  logic                  reset,
  sampler_voice_mixer_if.slave  bus
);

  localparam int unsigned ACC_WIDTH = acc_width(NUM_VOICES, SAMPLE_WIDTH, GAIN_WIDTH);
  localparam int unsigned IDX_WIDTH = (NUM_VOICES > 1) ? 32'($clog2(NUM_VOICES)) : 32'd1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_VOICES - 1);

  mixer_state_t              state, state_next;
  logic [IDX_WIDTH-1:0]      idx, idx_next;
  logic                      mac_clr, mac_en, mac_finish;
  logic [NUM_VOICES-1:0]     ready_c;
  logic                      wr_c;
  logic                      under_inc, clip_inc, overrun_set;
  logic                      clip_l, clip_r;
  logic signed [SAMPLE_WIDTH-1:0] res_l, res_r;
  logic [STAT_WIDTH-1:0]     clip_q, under_q;
  logic                      overrun_q;

  logic signed [SAMPLE_WIDTH-1:0] smp_l [NUM_VOICES];
  logic signed [SAMPLE_WIDTH-1:0] smp_r [NUM_VOICES];
  logic [GAIN_WIDTH-1:0]          gain_arr [NUM_VOICES];

  // Unpack the flat voice buses; left channel is the upper half of each word.
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_unpack
    assign smp_l[i]    = bus.voice_data[i*2*SAMPLE_WIDTH + SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign smp_r[i]    = bus.voice_data[i*2*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign gain_arr[i] = bus.voice_gain[i*GAIN_WIDTH +: GAIN_WIDTH];
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_finish  = 1'b0;
    ready_c     = '0;
    wr_c        = 1'b0;
    under_inc   = 1'b0;
    clip_inc    = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_req) begin
          mac_clr    = 1'b1;
          idx_next   = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.voice_en[idx]) begin
          if (bus.voice_valid[idx]) begin
            ready_c[idx] = 1'b1;
            mac_en       = 1'b1;
          end else begin
            under_inc = 1'b1;
          end
        end
        if (idx == LAST_IDX) begin
          state_next = SAT;
        end else begin
          idx_next = idx + IDX_WIDTH'(1);
        end
      end
      SAT: begin
        mac_finish = 1'b1;
        clip_inc   = clip_l | clip_r;
        state_next = OUTPUT;
      end
      OUTPUT: begin
        if (!bus.fifo_full) begin
          wr_c       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.frame_req && (state != IDLE)) begin
      overrun_set = 1'b1;
    end
  end

  sampler_mix_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .GAIN_WIDTH   (GAIN_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac_l (
    .clk     (axi_clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .sample  (smp_l[idx]),
    .gain    (gain_arr[idx]),
    .finish  (mac_finish),
    .result  (res_l),
    .clipped (clip_l)
  );

  sampler_mix_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .GAIN_WIDTH   (GAIN_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac_r (
    .clk     (axi_clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .sample  (smp_r[idx]),
    .gain    (gain_arr[idx]),
    .finish  (mac_finish),
    .result  (res_r),
    .clipped (clip_r)
  );

  // Statistics: saturating counters; clear_stats overrides any same-cycle update.
  always_ff @(posedge axi_clk) begin
    if (reset || bus.clear_stats) begin
      clip_q    <= '0;
      under_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (clip_inc && (clip_q != '1)) begin
        clip_q <= clip_q + STAT_WIDTH'(1);
      end
      if (under_inc && (under_q != '1)) begin
        under_q <= under_q + STAT_WIDTH'(1);
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.voice_ready    = ready_c;
  assign bus.data_wr        = wr_c;
  assign bus.busy           = (state != IDLE);
  assign bus.data_out       = {res_l, res_r};
  assign bus.clip_count     = clip_q;
  assign bus.underrun_count = under_q;
  assign bus.frame_overrun  = overrun_q;

endmodule

// File: tb/tb_sampler_voice_mixer.sv
// Directed bench for sampler_voice_mixer: a vector table of single frames plus
// hand sequences for clear-on-SAT, FIFO stall with overrun, and mid-frame reset.
module tb_sampler_voice_mixer;

  localparam logic [15:0] U = 16'h8000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sampler_voice_mixer_if #(.NUM_VOICES(4), .SAMPLE_WIDTH(24), .GAIN_WIDTH(16), .STAT_WIDTH(16)) bus ();

  sampler_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(24), .GAIN_WIDTH(16), .STAT_WIDTH(16)) dut (
    .axi_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   en;
    logic [3:0]   valid;
    logic [63:0]  gain;
    logic [191:0] data;
    logic [47:0]  exp_data;
    logic [15:0]  exp_clip;
    logic [15:0]  exp_under;
    logic [3:0]   exp_rdy;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [191:0] d4(input logic [23:0] l0, r0, l1, r1, l2, r2, l3, r3);
    return {l3, r3, l2, r2, l1, r1, l0, r0};
  endfunction

  function automatic logic [63:0] g4(input logic [15:0] g0, g1, g2, g3);
    return {g3, g2, g1, g0};
  endfunction

  function automatic vec_t mk(input string n, input logic [3:0] en, valid,
                              input logic [63:0] g, input logic [191:0] d,
                              input logic [47:0] ed, input logic [15:0] ec, eu,
                              input logic [3:0] er);
    vec_t v;
    v.name = n; v.en = en; v.valid = valid; v.gain = g; v.data = d;
    v.exp_data = ed; v.exp_clip = ec; v.exp_under = eu; v.exp_rdy = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1;
    bus.clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.clear_stats = 1'b0;
  endtask

  // Issues one frame_req (cycle 0) and observes 30 cycles; cycle c is the
  // window after clock edge c-1. fifo_full is held until cycle stall_until.
  task automatic run_frame(input vec_t v, input int stall_until, input int req2_cycle,
                           input int clear_cycle, output int wr_cnt, output int wr_cyc,
                           output logic [47:0] wr_dat, output logic [3:0] rdy_mask,
                           output int rdy0_cnt, output int rdy0_cyc, output bit stable);
    logic [47:0] held;
    wr_cnt = 0; wr_cyc = -1; wr_dat = '0; rdy_mask = '0;
    rdy0_cnt = 0; rdy0_cyc = -1; stable = 1'b1; held = '0;
    @(posedge clk); #1;
    bus.voice_en    = v.en;
    bus.voice_valid = v.valid;
    bus.voice_gain  = v.gain;
    bus.voice_data  = v.data;
    bus.fifo_full   = (stall_until > 0);
    bus.frame_req   = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      bus.frame_req   = (c == req2_cycle);
      bus.clear_stats = (c == clear_cycle);
      if (c >= stall_until) bus.fifo_full = 1'b0;
      @(negedge clk);
      rdy_mask = rdy_mask | bus.voice_ready;
      if (bus.voice_ready[0]) begin
        rdy0_cnt++;
        if (rdy0_cyc < 0) rdy0_cyc = c;
      end
      if (bus.data_wr) begin
        wr_cnt++;
        wr_cyc = c;
        wr_dat = bus.data_out;
      end
      if (c == 6) held = bus.data_out;
      if (c > 6 && c <= stall_until && bus.data_out !== held) stable = 1'b0;
    end
    bus.frame_req   = 1'b0;
    bus.clear_stats = 1'b0;
  endtask

  initial begin
    int          wr_cnt, wr_cyc, rdy0_cnt, rdy0_cyc, late_wr;
    logic [47:0] wr_dat;
    logic [3:0]  rdy_mask;
    bit          stable;

    n_checks = 0;
    n_fail   = 0;
    reset            = 1'b1;
    bus.voice_en     = '0;
    bus.voice_gain   = '0;
    bus.voice_valid  = '0;
    bus.voice_data   = '0;
    bus.frame_req    = 1'b0;
    bus.fifo_full    = 1'b0;
    bus.clear_stats  = 1'b0;

    vecs[0] = mk("solo_v0", 4'b0001, 4'b1111, g4(U, U, U, U),
                 d4(24'h000100, 24'hFFFF00, 24'h123456, 24'h654321,
                    24'h111111, 24'h222222, 24'h333333, 24'h444444),
                 48'h000100FFFF00, 16'd0, 16'd0, 4'b0001);
    vecs[1] = mk("all_clip", 4'b1111, 4'b1111, g4(U, U, U, U),
                 d4(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000,
                    24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000),
                 48'h7FFFFF800000, 16'd1, 16'd0, 4'b1111);
    vecs[2] = mk("half_gain_floor", 4'b0001, 4'b0001, g4(16'h4000, U, U, U),
                 d4(24'h000200, 24'hFFFFFD, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0),
                 48'h000100FFFFFE, 16'd0, 16'd0, 4'b0001);
    vecs[3] = mk("underrun", 4'b0011, 4'b0001, g4(U, U, U, U),
                 d4(24'h10, 24'h10, 24'h10, 24'h10, 24'h10, 24'h10, 24'h10, 24'h10),
                 48'h000010000010, 16'd0, 16'd1, 4'b0001);
    vecs[4] = mk("mixed_gains", 4'b1111, 4'b1111, g4(16'h8000, 16'h4000, 16'h0000, 16'hC000),
                 d4(24'h000010, 24'h000020, 24'h000100, 24'hFFFF00,
                    24'h001000, 24'h000000, 24'h000004, 24'h000008),
                 48'h000096FFFFAC, 16'd0, 16'd0, 4'b1111);
    vecs[5] = mk("max_gain_edge", 4'b0001, 4'b0001, g4(16'hFFFF, U, U, U),
                 d4(24'h400000, 24'hC00000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0),
                 48'h7FFF80800080, 16'd0, 16'd0, 4'b0001);
    vecs[6] = mk("one_side_clip", 4'b0011, 4'b0011, g4(U, U, U, U),
                 d4(24'h600000, 24'h000001, 24'h600000, 24'h000001,
                    24'h0, 24'h0, 24'h0, 24'h0),
                 48'h7FFFFF000002, 16'd1, 16'd0, 4'b0011);
    vecs[7] = mk("all_disabled", 4'b0000, 4'b1111, g4(U, U, U, U),
                 d4(24'h123456, 24'h654321, 24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6),
                 48'h000000000000, 16'd0, 16'd0, 4'b0000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_data_out", 64'(bus.data_out), 64'h0);
    check("reset_data_wr", 64'(bus.data_wr), 64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_ready", 64'(bus.voice_ready), 64'h0);
    check("reset_counters", 64'({bus.clip_count, bus.underrun_count, bus.frame_overrun}), 64'h0);

    foreach (vecs[i]) begin
      clear_pulse();
      run_frame(vecs[i], 0, -1, -1, wr_cnt, wr_cyc, wr_dat, rdy_mask, rdy0_cnt, rdy0_cyc, stable);
      check({vecs[i].name, "_wr_count"}, 64'(wr_cnt), 64'd1);
      check({vecs[i].name, "_wr_cycle"}, 64'(wr_cyc), 64'd6);
      check({vecs[i].name, "_data"}, 64'(wr_dat), 64'(vecs[i].exp_data));
      check({vecs[i].name, "_data_held"}, 64'(bus.data_out), 64'(vecs[i].exp_data));
      check({vecs[i].name, "_clip"}, 64'(bus.clip_count), 64'(vecs[i].exp_clip));
      check({vecs[i].name, "_underrun"}, 64'(bus.underrun_count), 64'(vecs[i].exp_under));
      check({vecs[i].name, "_ready_mask"}, 64'(rdy_mask), 64'(vecs[i].exp_rdy));
      check({vecs[i].name, "_ready0_pulses"}, 64'(rdy0_cnt), 64'(vecs[i].exp_rdy[0]));
      check({vecs[i].name, "_ready0_cycle"}, 64'(rdy0_cyc),
            vecs[i].exp_rdy[0] ? 64'd1 : 64'(-1));
      check({vecs[i].name, "_overrun"}, 64'(bus.frame_overrun), 64'h0);
    end

    // Clipping frame twice; the second clears on its SAT cycle (cycle 5).
    clear_pulse();
    run_frame(vecs[1], 0, -1, -1, wr_cnt, wr_cyc, wr_dat, rdy_mask, rdy0_cnt, rdy0_cyc, stable);
    check("clip_before_clear", 64'(bus.clip_count), 64'd1);
    run_frame(vecs[1], 0, -1, 5, wr_cnt, wr_cyc, wr_dat, rdy_mask, rdy0_cnt, rdy0_cyc, stable);
    check("clear_on_sat_clip", 64'(bus.clip_count), 64'd0);
    check("clear_on_sat_data", 64'(wr_dat), 64'h7FFFFF800000);

    // FIFO full for cycles 6..15 with a second request dropped at cycle 10.
    clear_pulse();
    run_frame(vecs[0], 16, 10, -1, wr_cnt, wr_cyc, wr_dat, rdy_mask, rdy0_cnt, rdy0_cyc, stable);
    check("stall_wr_count", 64'(wr_cnt), 64'd1);
    check("stall_wr_cycle", 64'(wr_cyc), 64'd16);
    check("stall_data_stable", 64'(stable), 64'd1);
    check("stall_data", 64'(wr_dat), 64'h000100FFFF00);
    check("stall_overrun_set", 64'(bus.frame_overrun), 64'd1);
    clear_pulse();
    @(negedge clk);
    check("overrun_cleared", 64'(bus.frame_overrun), 64'd0);

    // Reset asserted during ACCUM slot 2 after an underrun in slot 1.
    clear_pulse();
    @(posedge clk); #1;
    bus.voice_en    = 4'b0011;
    bus.voice_valid = 4'b0001;
    bus.voice_gain  = g4(U, U, U, U);
    bus.voice_data  = vecs[3].data;
    bus.frame_req   = 1'b1;
    @(posedge clk); #1;
    bus.frame_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("pre_reset_underrun", 64'(bus.underrun_count), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_ready", 64'(bus.voice_ready), 64'd0);
    check("midreset_counters", 64'({bus.clip_count, bus.underrun_count, bus.frame_overrun}), 64'h0);
    late_wr = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.data_wr) late_wr++;
    end
    check("midreset_no_write", 64'(late_wr), 64'd0);
    run_frame(vecs[0], 0, -1, -1, wr_cnt, wr_cyc, wr_dat, rdy_mask, rdy0_cnt, rdy0_cyc, stable);
    check("post_reset_wr_count", 64'(wr_cnt), 64'd1);
    check("post_reset_data", 64'(wr_dat), 64'h000100FFFF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
